peripheral_dbg_soc_osd_dem_uart_ahb3_bridge: RTL and testbench
==============================================================

Name: peripheral_dbg_soc_osd_dem_uart_ahb3_bridge

Overview:
AHB3-Lite slave front-end that converts pipelined AHB transfers into the byte-wide req/ack register bus of the debug UART 16550 register model. It sits directly upstream of that register model.
- Separates address and data phases.
- Inserts wait states until the register model acks.
- Returns registered, lane-replicated read data.
- Generates the two-cycle AHB ERROR response for unsupported transfers.

Parameters:
XLEN, 32, AHB data width in bits; must be 32 or 64.
ADDR_SHIFT, 2, byte-address bit where the 3-bit register index starts: 2 = word-spaced registers, 0 = byte-spaced.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles without bus_ack; used only with the optional feature; range 1..255.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous active-low reset.
ahb3_hsel_i  in  1  slave select.
ahb3_haddr_i  in  16  byte address.
ahb3_hwdata_i  in  XLEN  write data, valid in the data phase.
ahb3_hwrite_i  in  1  1 = write.
ahb3_hsize_i  in  3  transfer size.
ahb3_htrans_i  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
ahb3_hready_i  in  1  bus-level HREADY; qualifies the address phase.
ahb3_hrdata_o  out  XLEN  read data.
ahb3_hready_o  out  1  slave ready.
ahb3_hresp_o  out  1  1 = ERROR.
bus_req  out  1  register access request.
bus_addr  out  3  register index.
bus_write  out  1  1 = register write.
bus_wdata  out  8  register write byte.
bus_ack  in  1  single-cycle completion from the register model.
bus_rdata  in  8  register read byte, valid with bus_ack.

Behaviour:
- Reset values: rst low at any time, asynchronously:
  - state = IDLE; ahb3_hready_o = 1; ahb3_hresp_o = 0; ahb3_hrdata_o = 0.
  - bus_req = 0; bus_addr = 0; bus_write = 0.
  - An access in flight is abandoned without an ack.
- Address-phase accept: accept = hsel_i & htrans_i[1] & hready_i, evaluated only in IDLE, RESP and ERR2.
- On accept, register:
  - addr_q = haddr_i[ADDR_SHIFT+2:ADDR_SHIFT]
  - lane_q = haddr_i[log2(XLEN/8)-1:0]
  - write_q = hwrite_i
- Error check: if hsize_i > log2(XLEN/8), go to ERR1. Otherwise go to ACCESS.
- ACCESS:
  - bus_req = 1, bus_addr = addr_q, bus_write = write_q, ahb3_hready_o = 0.
  - bus_wdata = ahb3_hwdata_i[8*lane_q +: 8], taken combinationally; AHB holds hwdata stable during wait states.
  - On bus_ack: hrdata_o <= {XLEN/8{bus_rdata}} (reads only; unchanged on writes), then go to RESP. bus_req is low from the next cycle.
- RESP: hready_o = 1, hresp_o = 0 for one cycle. Accept here goes to ACCESS or ERR1; no accept goes to IDLE.
- ERR1: hready_o = 0, hresp_o = 1, bus_req = 0, then go to ERR2.
- ERR2: hready_o = 1, hresp_o = 1. Accept here goes to ACCESS or ERR1; no accept goes to IDLE.
- IDLE: hready_o = 1, hresp_o = 0.
- Latency: address phase in cycle N; bus_req high in N+1. With ack in N+1, RESP (hready high) is in N+2. Minimum 2 data-phase cycles per transfer.
- Ignored inputs:
  - bus_ack outside ACCESS is ignored.
  - IDLE and BUSY htrans produce an OKAY zero-wait response (stay in the current ready state).
  - hsel_i low while hready_i is high is ignored.
- ahb3_hrdata_o holds its last value until the next read completes.

Optional Feature:
DEM_UART_AHB3_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES, bus_req drops and the FSM goes to ERR1.
  - bus_ack in the same cycle as the timeout wins (normal RESP).
  - A late ack is ignored.
- Undefined: ACCESS waits indefinitely for bus_ack. No counter logic is synthesised.

Decomposition:
- Package peripheral_dbg_soc_dem_uart_bridge_pkg:
  - state enum {IDLE, ACCESS, RESP, ERR1, ERR2}.
  - HTRANS constants (IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11).
  - HRESP_OKAY = 0, HRESP_ERROR = 1.
- Sub-module peripheral_dbg_soc_osd_dem_uart_ahb3_wdog: timeout counter with clear, enable and expire. Instantiated only under DEM_UART_AHB3_TIMEOUT_EN.

Test Plan:
- Reset: rst low mid-ACCESS → same cycle: bus_req = 0, hready_o = 1, hresp_o = 0. After release, state is IDLE.
- Write: NONSEQ write, haddr = 0x000C, hsize = 2, hwdata = 0x000000A5, ack after 3 cycles → bus_addr = 3, bus_write = 1, bus_wdata = 0xA5. bus_req high for exactly 3 cycles. hready_o low 3 cycles, then high 1 cycle.
- Read: haddr = 0x0014, bus_rdata = 0x5C with immediate ack → bus_addr = 5. hrdata_o = 0x5C5C5C5C in the RESP cycle. hresp_o = 0.
- Back-to-back: second NONSEQ presented in the RESP cycle → accepted without an IDLE gap. bus_req re-asserts the next cycle with the new address.
- Error: hsize = 3 with XLEN = 32 → bus_req never asserts. hready_o/hresp_o = 0/1, then 1/1. A following valid transfer completes OKAY.
- Timeout (macro defined, TIMEOUT_CYCLES = 4, no ack) → bus_req high 4 cycles, then ERR1/ERR2 sequence. A stray ack 2 cycles later causes no state change.

Source files
------------

// File: rtl/peripheral_dbg_soc_dem_uart_bridge_pkg.sv
// Shared types and AHB3-Lite encodings for the debug UART AHB3 bridge.
package peripheral_dbg_soc_dem_uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_dbg_soc_osd_dem_uart_ahb3_wdog.sv
// ACCESS-phase watchdog: counts cycles without an ack and flags expiry on the
// last allowed cycle. Only instantiated when DEM_UART_AHB3_TIMEOUT_EN is defined.
module peripheral_dbg_soc_osd_dem_uart_ahb3_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Fires in the cycle whose increment would reach TIMEOUT_CYCLES.
    assign expire = enable && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peripheral_dbg_soc_osd_dem_uart_ahb3_bridge.sv
// AHB3-Lite slave to byte-wide req/ack register bus bridge for the debug UART.
// Optional ACCESS timeout enabled by defining DEM_UART_AHB3_TIMEOUT_EN.
module peripheral_dbg_soc_osd_dem_uart_ahb3_bridge
    import peripheral_dbg_soc_dem_uart_bridge_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_SHIFT     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb3_hsel_i,
    input  logic [15:0]     ahb3_haddr_i,
    input  logic [XLEN-1:0] ahb3_hwdata_i,
    input  logic            ahb3_hwrite_i,
    input  logic [2:0]      ahb3_hsize_i,
    input  logic [1:0]      ahb3_htrans_i,
    input  logic            ahb3_hready_i,
    output logic [XLEN-1:0] ahb3_hrdata_o,
    output logic            ahb3_hready_o,
    output logic            ahb3_hresp_o,
    output logic            bus_req,
    output logic [2:0]      bus_addr,
    output logic            bus_write,
    output logic [7:0]      bus_wdata,
    input  logic            bus_ack,
    input  logic [7:0]      bus_rdata
);

    localparam int LANE_W = $clog2(XLEN / 8);

    state_t            state, next_state;
    logic [2:0]        addr_q;
    logic [LANE_W-1:0] lane_q;
    logic              write_q;
    logic              ready_state;
    logic              accept;
    logic              size_err;
    logic              expire;
    logic              unused_bits;

    assign ready_state = (state == IDLE) || (state == RESP) || (state == ERR2);
    assign accept      = ready_state && ahb3_hsel_i && ahb3_htrans_i[1] && ahb3_hready_i;
    assign size_err    = ahb3_hsize_i > 3'(LANE_W);
    assign unused_bits = ^{ahb3_haddr_i, ahb3_htrans_i[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 3'd0;
            lane_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= ahb3_haddr_i[ADDR_SHIFT+2:ADDR_SHIFT];
            lane_q  <= ahb3_haddr_i[LANE_W-1:0];
            write_q <= ahb3_hwrite_i;
        end
    end

    // Read data is replicated on every byte lane so any lane offset sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ahb3_hrdata_o <= '0;
        end else if ((state == ACCESS) && bus_ack && !write_q) begin
            ahb3_hrdata_o <= {(XLEN/8){bus_rdata}};
        end
    end

    always_comb begin
        next_state    = state;
        ahb3_hready_o = 1'b1;
        ahb3_hresp_o  = HRESP_OKAY;
        bus_req       = 1'b0;
        case (state)
            IDLE, RESP, ERR2: begin
                if (state == ERR2) begin
                    ahb3_hresp_o = HRESP_ERROR;
                end
                if (accept) begin
                    next_state = size_err ? ERR1 : ACCESS;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS: begin
                bus_req       = 1'b1;
                ahb3_hready_o = 1'b0;
                if (bus_ack) begin
                    next_state = RESP;
                end else if (expire) begin
                    next_state = ERR1;
                end
            end
            ERR1: begin
                ahb3_hready_o = 1'b0;
                ahb3_hresp_o  = HRESP_ERROR;
                next_state    = ERR2;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus_addr  = addr_q;
    assign bus_write = write_q && bus_req;
    // hwdata is held stable by the master across wait states.
    assign bus_wdata = ahb3_hwdata_i[{lane_q, 3'b000} +: 8];

`ifdef DEM_UART_AHB3_TIMEOUT_EN
    peripheral_dbg_soc_osd_dem_uart_ahb3_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state != ACCESS),
        .enable((state == ACCESS) && !bus_ack),
        .expire(expire)
    );
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_dem_uart_ahb3_bridge.sv
// Self-checking bench for the debug UART AHB3 bridge: vector table plus
// hand-written sequences, register accesses checked through a scoreboard.
module tb_peripheral_dbg_soc_osd_dem_uart_ahb3_bridge;
    import peripheral_dbg_soc_dem_uart_bridge_pkg::*;

    typedef struct {
        logic [15:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic [7:0]  rdata;
        int          ack_delay;
        int          exp_req;
        int          exp_wait;
        logic        exp_err;
        logic [2:0]  exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    typedef struct {
        logic [2:0] addr;
        logic       write;
        logic [7:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsel = 1'b0;
    logic [15:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hready_bus;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        bus_req;
    logic [2:0]  bus_addr;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_rdata;

    logic [7:0]  rdata_val = '0;
    int          ack_delay = 0;
    int          req_cnt = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] model_hrdata = '0;
    acc_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs[8];

    assign hready_bus = hready;
    assign bus_rdata  = rdata_val;

    always #5 clk = ~clk;

    peripheral_dbg_soc_osd_dem_uart_ahb3_bridge #(
        .XLEN(32),
        .ADDR_SHIFT(2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ahb3_hsel_i  (hsel),
        .ahb3_haddr_i (haddr),
        .ahb3_hwdata_i(hwdata),
        .ahb3_hwrite_i(hwrite),
        .ahb3_hsize_i (hsize),
        .ahb3_htrans_i(htrans),
        .ahb3_hready_i(hready_bus),
        .ahb3_hrdata_o(hrdata),
        .ahb3_hready_o(hready),
        .ahb3_hresp_o (hresp),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_write    (bus_write),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register model: acks after ack_delay request cycles (0 = never).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                req_cnt = 0;
                bus_ack = 1'b0;
            end else if (bus_req) begin
                req_cnt++;
                bus_ack = (ack_delay != 0) && (req_cnt == ack_delay);
            end else begin
                req_cnt = 0;
                bus_ack = stray_ack;
            end
        end
    end

    // Scoreboard: every acked register access must match the next expectation.
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (rst && bus_req && bus_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_addr", 32'(bus_addr), 32'(e.addr));
                    check("bus_write", 32'(bus_write), 32'(e.write));
                    if (e.write) begin
                        check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                    end
                end
            end
        end
    end

    task automatic drive_addr(input logic [15:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        haddr  = a;
        hwrite = w;
        hsize  = s;
        htrans = HTRANS_NONSEQ;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Waits for hready high, counting wait and request cycles.
    task automatic wait_done(input string name, output int low, output int req, output logic last_low_resp);
        bit done = 0;
        low = 0;
        req = 0;
        last_low_resp = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_req) req++;
            if (!hready) begin
                low++;
                last_low_resp = hresp;
            end else begin
                done = 1;
                break;
            end
        end
        if (!done) check({name, "_hready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        int   low, req;
        logic llr;
        @(posedge clk); #1;
        drive_addr(v.haddr, v.hwrite, v.hsize);
        ack_delay = v.ack_delay;
        rdata_val = v.rdata;
        if (!v.exp_err && v.ack_delay != 0) begin
            exp_q.push_back('{v.exp_addr, v.hwrite, v.exp_wdata});
            if (!v.hwrite) model_hrdata = {4{v.rdata}};
        end
        @(posedge clk); #1;
        drive_idle();
        hwdata = v.hwdata;
        wait_done(name, low, req, llr);
        check_output(name, low, req, llr, v);
    endtask

    task automatic check_output(input string name, input int low, input int req, input logic llr, input vec_t v);
        check({name, "_req_cycles"}, 32'(req), 32'(v.exp_req));
        check({name, "_wait_cycles"}, 32'(low), 32'(v.exp_wait));
        check({name, "_resp_wait"}, 32'(llr), 32'(v.exp_err));
        check({name, "_resp_final"}, 32'(hresp), 32'(v.exp_err));
        check({name, "_hrdata"}, hrdata, model_hrdata);
    endtask

    initial begin
        int   low, req;
        logic llr;
        vec_t tv;

        vecs[0] = '{16'h000C, 1'b1, 3'd2, 32'h0000_00A5, 8'h00, 3, 3, 3, 1'b0, 3'd3, 8'hA5};
        vecs[1] = '{16'h0014, 1'b0, 3'd2, 32'h0000_0000, 8'h5C, 1, 1, 1, 1'b0, 3'd5, 8'h00};
        vecs[2] = '{16'h0005, 1'b1, 3'd0, 32'h0000_7700, 8'h00, 2, 2, 2, 1'b0, 3'd1, 8'h77};
        vecs[3] = '{16'h001E, 1'b0, 3'd1, 32'h0000_0000, 8'h3A, 2, 2, 2, 1'b0, 3'd7, 8'h00};
        vecs[4] = '{16'h0027, 1'b1, 3'd0, 32'hEE00_0000, 8'h00, 1, 1, 1, 1'b0, 3'd1, 8'hEE};
        vecs[5] = '{16'h0008, 1'b1, 3'd3, 32'h0000_00FF, 8'h00, 1, 0, 1, 1'b1, 3'd2, 8'hFF};
        vecs[6] = '{16'h0010, 1'b1, 3'd2, 32'h0000_0011, 8'h00, 1, 1, 1, 1'b0, 3'd4, 8'h11};
        vecs[7] = '{16'h001C, 1'b0, 3'd2, 32'h0000_0000, 8'h00, 4, 4, 4, 1'b0, 3'd7, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_write", 32'(bus_write), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // BUSY and deselected NONSEQ are both ignored.
        @(posedge clk); #1;
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 16'h0004;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_NONSEQ;
        @(negedge clk);
        check("busy_ignored_req", 32'(bus_req), 32'd0);
        check("busy_ignored_hready", 32'(hready), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("hsel_low_ignored", 32'(bus_req), 32'd0);

        // Back-to-back: second address phase presented in the RESP cycle.
        @(posedge clk); #1;
        drive_addr(16'h0004, 1'b0, 3'd2);
        ack_delay = 1;
        rdata_val = 8'h96;
        exp_q.push_back('{3'd1, 1'b0, 8'h00});
        model_hrdata = 32'h9696_9696;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("b2b_a_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        drive_addr(16'h0018, 1'b1, 3'd2);
        ack_delay = 2;
        exp_q.push_back('{3'd6, 1'b1, 8'h3C});
        @(negedge clk);
        check("b2b_resp_hready", 32'(hready), 32'd1);
        check("b2b_resp_hrdata", hrdata, model_hrdata);
        @(posedge clk); #1;
        drive_idle();
        hwdata = 32'h0000_003C;
        @(negedge clk);
        check("b2b_b_req", 32'(bus_req), 32'd1);
        check("b2b_b_addr", 32'(bus_addr), 32'd6);
        wait_done("b2b_b", low, req, llr);
        check("b2b_b_wait", 32'(low + 1), 32'd2);
        check("b2b_b_resp", 32'(hresp), 32'd0);

        // Reset asserted in the middle of an unacked access.
        @(posedge clk); #1;
        drive_addr(16'h0008, 1'b0, 3'd2);
        ack_delay = 0;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("mid_access_req", 32'(bus_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_req", 32'(bus_req), 32'd0);
        check("async_rst_hready", 32'(hready), 32'd1);
        check("async_rst_hresp", 32'(hresp), 32'd0);
        model_hrdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_req", 32'(bus_req), 32'd0);
        check("post_rst_hready", 32'(hready), 32'd1);
        check("post_rst_hrdata", hrdata, 32'd0);

`ifdef DEM_UART_AHB3_TIMEOUT_EN
        tv = '{16'h0004, 1'b0, 3'd2, 32'h0, 8'h00, 0, 4, 5, 1'b1, 3'd1, 8'h00};
        apply_stimulus(tv, "timeout");
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #3;
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", 32'(bus_req), 32'd0);
        check("stray_ack_hready", 32'(hready), 32'd1);
        check("stray_ack_hresp", 32'(hresp), 32'd0);
`else
        tv = vecs[6];
        apply_stimulus(tv, "final_write");
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

endmodule
